add_sub_seq: RTL and testbench

//  Parametrised sequential adder/subtractor, the multi-cycle successor of the 16-bit ripple adder.

---
 rtl/add_sub_seq.sv | 165 ++++++++++++++++
 tb/tb_add_sub_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_seq.sv
// -----------------------------------------------------------------------------
// add_sub_seq
// Sequential adder/subtractor. It processes CHUNK bits per clock, so one
// WIDTH-bit operation takes WIDTH/CHUNK cycles. The carry passes between chunks
// in a register, which keeps the ripple depth per cycle at CHUNK bits.
// It reports the raw carry-out, the signed overflow and a zero flag, and has
// valid/ready handshakes on both the input side and the output side.
//
// Parameters
//   WIDTH      operand/result width in bits
//   CHUNK      bits processed per cycle; must divide WIDTH
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   in_valid   operands/controls valid
//   in_ready   an operation can be accepted this cycle
//   a, b       operands
//   sub        0: a+b+carry_in, 1: a-b-carry_in
//   carry_in   carry (add) / borrow (sub) input
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   sum        result modulo 2^WIDTH
//   carry_out  raw carry out of the MSB (sub: 1 = no borrow)
//   overflow   signed overflow
//   zero       sum == 0
// -----------------------------------------------------------------------------
module add_sub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int            NCH      = WIDTH / CHUNK;
    localparam int            IW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;       // already inverted for subtract
    logic             r_carry;   // carry chain between chunks
    logic [WIDTH-1:0] r_sum;
    logic             r_out_valid;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    int               w_base;
    logic [CHUNK-1:0] w_a_ch;
    logic [CHUNK-1:0] w_b_ch;
    logic [CHUNK:0]   w_ch_res;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_msb_cin;
    logic             w_last;
    logic             w_accept;

    // A new operation may enter while idle, or while the previous result is
    // being handed off in DONE (accept overlaps the output transfer).
    assign in_ready = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_idx == LAST_IDX);

    // Chunk adder: one CHUNK-bit slice of a and b' plus the registered carry.
    always_comb begin
        w_base     = int'(r_idx) * CHUNK;
        w_a_ch     = r_a[w_base +: CHUNK];
        w_b_ch     = r_b[w_base +: CHUNK];
        w_ch_res   = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_carry};
        w_sum_next = r_sum;
        w_sum_next[w_base +: CHUNK] = w_ch_res[CHUNK-1:0];
        // On the last chunk the top slice bit is bit WIDTH-1, so this
        // recovers the carry into the MSB for the overflow flag.
        w_msb_cin  = w_a_ch[CHUNK-1] ^ w_b_ch[CHUNK-1] ^ w_ch_res[CHUNK-1];
    end

    // Operand capture: data only, no reset needed. Subtract is a + ~b + ~cin.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= sub ? ~b : b;
        end
    end

    // Control FSM with registered result and flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_carry <= sub ? ~carry_in : carry_in;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_ch_res[CHUNK];
                    if (w_last) begin
                        r_cout      <= w_ch_res[CHUNK];
                        r_ovf       <= w_ch_res[CHUNK] ^ w_msb_cin;
                        r_zero      <= (w_sum_next == '0);
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    // Result and flags stay put until the consumer takes them.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_carry <= sub ? ~carry_in : carry_in;
                            r_idx   <= '0;
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_add_sub_seq.sv
// -----------------------------------------------------------------------------
// tb_add_sub_seq
// Three instances (CHUNK = 1, 4, 16, WIDTH = 16) share this bench. Directed
// steps run on the CHUNK=4 instance; the random run exercises each instance in
// turn. Expected results are queued at acceptance and compared by a monitor
// when each result is handed off.
// -----------------------------------------------------------------------------
module tb_add_sub_seq;

    localparam int W = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  in_valid_v;
    logic [2:0]  sub_v;
    logic [2:0]  cin_v;
    logic [2:0]  rdy_ctl;
    logic [2:0]  rnd_bit;
    logic        stall_en;
    logic [W-1:0] a_v [3];
    logic [W-1:0] b_v [3];

    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [2:0]  cout_v;
    logic [2:0]  ovf_v;
    logic [2:0]  zero_v;
    logic [2:0]  out_rdy;
    logic [W-1:0] sum_v [3];

    logic [18:0] q0 [$];
    logic [18:0] q1 [$];
    logic [18:0] q2 [$];

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) rnd_bit[k] <= ($urandom_range(0, 3) != 0);
    end

    assign out_rdy[0] = rdy_ctl[0] & (~stall_en | rnd_bit[0]);
    assign out_rdy[1] = rdy_ctl[1] & (~stall_en | rnd_bit[1]);
    assign out_rdy[2] = rdy_ctl[2] & (~stall_en | rnd_bit[2]);

    add_sub_seq #(.WIDTH(W), .CHUNK(1)) u_c1 (
        .clock(clock), .reset(reset), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .sub(sub_v[0]), .carry_in(cin_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_rdy[0]), .sum(sum_v[0]),
        .carry_out(cout_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0])
    );

    add_sub_seq #(.WIDTH(W), .CHUNK(4)) u_c4 (
        .clock(clock), .reset(reset), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]), .sub(sub_v[1]), .carry_in(cin_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_rdy[1]), .sum(sum_v[1]),
        .carry_out(cout_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1])
    );

    add_sub_seq #(.WIDTH(W), .CHUNK(16)) u_c16 (
        .clock(clock), .reset(reset), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .sub(sub_v[2]), .carry_in(cin_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_rdy[2]), .sum(sum_v[2]),
        .carry_out(cout_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2])
    );

    // Reference: full-width add, overflow from the operand/result sign rule.
    // Packed as {carry_out, overflow, zero, sum}.
    function automatic logic [18:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic s, input logic c);
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   r;
        logic         ov;
        bb = s ? ~bv : bv;
        ci = s ? ~c : c;
        r  = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, ci};
        ov = (av[W-1] == bb[W-1]) && (r[W-1] != av[W-1]);
        return {r[W], ov, (r[W-1:0] == '0), r[W-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic qpush(input int k, input logic [18:0] e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [18:0] qpop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Scoreboard monitor: compare every handed-off result against the queue.
    always @(negedge clock) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                if (out_valid_v[k] && out_rdy[k]) begin
                    if (qsize(k) == 0)
                        chk($sformatf("unexpected_out_dut%0d", k), 32'd1, 32'd0);
                    else
                        chk($sformatf("result_dut%0d", k),
                            {13'b0, cout_v[k], ovf_v[k], zero_v[k], sum_v[k]},
                            {13'b0, qpop(k)});
                end
            end
        end
    end

    // Present an operation and hold it until accepted; n = falling edges waited.
    task automatic drive_op(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic s, input logic c, output int n);
        bit acc;
        acc = 1'b0;
        n   = 0;
        a_v[k] = av; b_v[k] = bv; sub_v[k] = s; cin_v[k] = c;
        in_valid_v[k] = 1'b1;
        while (!acc && n < 400) begin
            @(negedge clock);
            n++;
            if (in_ready_v[k]) begin
                qpush(k, model(av, bv, s, c));
                acc = 1'b1;
            end
            @(posedge clock); #1;
        end
        in_valid_v[k] = 1'b0;
        if (!acc) chk($sformatf("accept_timeout_dut%0d", k), 32'd0, 32'd1);
    endtask

    // Wait for out_valid; n counts falling edges after the accept edge.
    task automatic wait_out(input int k, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!out_valid_v[k] && n < 200);
        if (!out_valid_v[k]) chk($sformatf("out_timeout_dut%0d", k), 32'd0, 32'd1);
    endtask

    // Directed op with out_ready high. A result registered at edge T+NCH is
    // first visible at the (NCH+1)th falling edge after the accept edge T.
    task automatic op_check(input string tag, input int k, input int nch,
                            input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic s, input logic c,
                            input logic [W-1:0] es, input logic ec, input logic eo,
                            input logic ez);
        int n;
        int lat;
        drive_op(k, av, bv, s, c, n);
        wait_out(k, lat);
        chk({tag, "_latency"}, lat, nch + 1);
        chk({tag, "_sum"},  {16'b0, sum_v[k]}, {16'b0, es});
        chk({tag, "_cout"}, {31'b0, cout_v[k]}, {31'b0, ec});
        chk({tag, "_ovf"},  {31'b0, ovf_v[k]},  {31'b0, eo});
        chk({tag, "_zero"}, {31'b0, zero_v[k]}, {31'b0, ez});
        @(posedge clock); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;
        reset      = 1'b1;
        in_valid_v = '0;
        sub_v      = '0;
        cin_v      = '0;
        rdy_ctl    = 3'b111;
        stall_en   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_v[k] = '0;
            b_v[k] = '0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state on all instances
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out_valid%0d", k), {31'b0, out_valid_v[k]}, 32'd0);
            chk($sformatf("rst_in_ready%0d", k),  {31'b0, in_ready_v[k]},  32'd1);
            chk($sformatf("rst_flags_sum%0d", k),
                {13'b0, cout_v[k], ovf_v[k], zero_v[k], sum_v[k]}, 32'd0);
        end
        @(posedge clock); #1;

        // Basic add, latency on every chunk size
        op_check("add_c4",  1, 4,  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        op_check("add_c1",  0, 16, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        op_check("add_c16", 2, 1,  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

        // Carry / overflow boundaries
        op_check("wrap",    1, 4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        op_check("posovf",  1, 4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

        // Subtract
        op_check("sub_neg", 1, 4, 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        op_check("sub_ovf", 1, 4, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        op_check("sub_bin", 1, 4, 16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);

        // Output stall: result held, no accept, input changes ignored
        rdy_ctl[1] = 1'b0;
        drive_op(1, 16'h1111, 16'h2222, 1'b0, 1'b0, n);
        wait_out(1, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            in_valid_v[1] = 1'b1;
            a_v[1]   = 16'($urandom);
            b_v[1]   = 16'($urandom);
            sub_v[1] = 1'($urandom);
            cin_v[1] = 1'($urandom);
            @(negedge clock);
            chk("stall_out_valid", {31'b0, out_valid_v[1]}, 32'd1);
            chk("stall_sum",       {16'b0, sum_v[1]},       32'h3333);
            chk("stall_in_ready",  {31'b0, in_ready_v[1]},  32'd0);
        end
        @(posedge clock); #1;
        in_valid_v[1] = 1'b0;
        rdy_ctl[1]    = 1'b1;
        drive_op(1, 16'h0100, 16'h0020, 1'b0, 1'b0, n);
        chk("handoff_accept_same_cycle", n, 32'd1);
        wait_out(1, lat);
        chk("handoff_latency", lat, 32'd5);
        chk("handoff_sum", {16'b0, sum_v[1]}, 32'h0120);
        @(posedge clock); #1;

        // Reset during the second RUN cycle aborts the operation
        drive_op(1, 16'h0F0F, 16'h0101, 1'b0, 1'b0, n);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        q1.delete();
        @(negedge clock);
        chk("abort_out_valid", {31'b0, out_valid_v[1]}, 32'd0);
        chk("abort_in_ready",  {31'b0, in_ready_v[1]},  32'd1);
        chk("abort_flags_sum", {13'b0, cout_v[1], ovf_v[1], zero_v[1], sum_v[1]}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("abort_no_out", {31'b0, out_valid_v[1]}, 32'd0);
        end
        @(posedge clock); #1;
        op_check("after_abort", 1, 4, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

        // Random operations with random output stalls, one instance at a time
        stall_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 1000; i++) begin
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clock); #1;
                end
                drive_op(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), n);
            end
            n = 0;
            while (qsize(k) != 0 && n < 2000) begin
                @(posedge clock); #1;
                n++;
            end
            chk($sformatf("drain_dut%0d", k), qsize(k), 32'd0);
        end
        stall_en = 1'b0;
        repeat (4) @(posedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
